// File: rtl/csr_pkg.sv
// Shared CSR bus definitions: bus widths, bridge FSM encodings and slave-select field.
package csr_pkg;

    localparam int CSR_AW = 15;
    localparam int CSR_DW = 32;

    // Upper bits of the CSR word address pick the slave; lower bits address within it.
    localparam int CSR_SEL_HI = 14;
    localparam int CSR_SEL_LO = 10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WRITE  = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;

    function automatic logic [CSR_SEL_HI-CSR_SEL_LO:0] csr_slave_sel(
        input logic [CSR_AW-1:0] addr
    );
        return addr[CSR_SEL_HI:CSR_SEL_LO];
    endfunction

endpackage

// File: rtl/csr_bus_bridge.sv
// Wishbone slave to CSR bus initiator. One access at a time, every output registered.
module csr_bus_bridge
    import csr_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    output logic              wb_ack_o,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [CSR_DW-1:0] csr_do,
    input  logic [CSR_DW-1:0] csr_di
);

    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_rd_latency
        $error("csr_bus_bridge: RD_LATENCY must be within 1..7");
    end

    // Address bits outside the word address are deliberately not decoded.
    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:17], wb_adr_i[1:0]};

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       dat_d;
    logic              ack_d;
    logic [CSR_AW-1:0] csr_a_d;
    logic              csr_we_d;
    logic [CSR_DW-1:0] csr_do_d;

    // Next-state and registered-output values for the access sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dat_d    = wb_dat_o;
        ack_d    = wb_ack_o;
        csr_a_d  = csr_a;
        csr_we_d = 1'b0;
        csr_do_d = csr_do;
        case (state_q)
            S_IDLE: begin
                // ~wb_ack_o keeps a stalled strobe from being taken twice.
                if (wb_cyc_i && wb_stb_i && !wb_ack_o) begin
                    csr_a_d  = wb_adr_i[16:2];
                    csr_do_d = wb_dat_i;
                    if (wb_we_i) begin
                        csr_we_d = 1'b1;
                        state_d  = S_WRITE;
                    end else begin
                        cnt_d   = 3'(RD_LATENCY);
                        state_d = S_RDWAIT;
                    end
                end
            end
            S_WRITE: begin
                ack_d   = 1'b1;
                state_d = S_ACK;
            end
            S_RDWAIT: begin
                // Slave samples csr_a one edge after it is driven, so the count
                // runs down to zero before capture: capture edge is accept+1+RD_LATENCY.
                if (cnt_q == 3'd0) begin
                    dat_d   = csr_di;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK: begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            wb_dat_o <= 32'd0;
            wb_ack_o <= 1'b0;
            csr_a    <= '0;
            csr_we   <= 1'b0;
            csr_do   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wb_dat_o <= dat_d;
            wb_ack_o <= ack_d;
            csr_a    <= csr_a_d;
            csr_we   <= csr_we_d;
            csr_do   <= csr_do_d;
        end
    end

endmodule

// File: tb/tb_csr_bus_bridge.sv
// Directed bench for csr_bus_bridge: default-latency instance plus an RD_LATENCY=3 instance.
module tb_csr_bus_bridge;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    always #5 sys_clk = ~sys_clk;

    // Default-latency instance (a_*)
    logic [31:0] a_adr, a_wdat, a_rdat, a_csr_do, a_csr_di;
    logic        a_cyc, a_stb, a_we, a_ack, a_csr_we;
    logic [14:0] a_csr_a;

    // RD_LATENCY=3 instance (b_*)
    logic [31:0] b_adr, b_wdat, b_rdat, b_csr_do, b_csr_di;
    logic        b_cyc, b_stb, b_we, b_ack, b_csr_we;
    logic [14:0] b_csr_a;

    int total = 0;
    int bad   = 0;

    csr_bus_bridge dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wb_adr_i(a_adr),
        .wb_dat_i(a_wdat),
        .wb_dat_o(a_rdat),
        .wb_cyc_i(a_cyc),
        .wb_stb_i(a_stb),
        .wb_we_i (a_we),
        .wb_ack_o(a_ack),
        .csr_a   (a_csr_a),
        .csr_we  (a_csr_we),
        .csr_do  (a_csr_do),
        .csr_di  (a_csr_di)
    );

    csr_bus_bridge #(.RD_LATENCY(3)) dut3 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wb_adr_i(b_adr),
        .wb_dat_i(b_wdat),
        .wb_dat_o(b_rdat),
        .wb_cyc_i(b_cyc),
        .wb_stb_i(b_stb),
        .wb_we_i (b_we),
        .wb_ack_o(b_ack),
        .csr_a   (b_csr_a),
        .csr_we  (b_csr_we),
        .csr_do  (b_csr_do),
        .csr_di  (b_csr_di)
    );

    // Slave models: a_* answers word 1 one edge after sampling csr_a; b_* has a 3-edge pipe.
    logic [31:0] b_s1 = 32'd0, b_s2 = 32'd0, b_s3 = 32'd0;
    logic [31:0] a_slave = 32'd0;
    always @(posedge sys_clk) begin
        a_slave <= (a_csr_a == 15'h0001) ? 32'h0000_07FF : 32'h0;
        b_s1    <= (b_csr_a == 15'h0002) ? 32'hCAFE_F00D : 32'h1111_0000;
        b_s2    <= b_s1;
        b_s3    <= b_s2;
    end
    assign a_csr_di = a_slave;
    assign b_csr_di = b_s3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        a_adr = 0; a_wdat = 0; a_cyc = 0; a_stb = 0; a_we = 0;
        b_adr = 0; b_wdat = 0; b_cyc = 0; b_stb = 0; b_we = 0;

        // Power-up reset
        #1 sys_rst = 1'b1;
        #1;
        chk("rst_ack",   {31'd0, a_ack},    32'd0);
        chk("rst_we",    {31'd0, a_csr_we}, 32'd0);
        chk("rst_csr_a", {17'd0, a_csr_a},  32'd0);
        chk("rst_rdat",  a_rdat,            32'd0);
        chk("rst_do",    a_csr_do,          32'd0);
        #20;
        @(negedge sys_clk) sys_rst = 1'b0;
        tick();

        // Write 0xDEADBEEF to byte address 0x1004
        a_adr = 32'h0000_1004; a_wdat = 32'hDEAD_BEEF; a_we = 1; a_cyc = 1; a_stb = 1;
        tick();
        chk("wr_csr_a",  {17'd0, a_csr_a},  32'h0401);
        chk("wr_csr_do", a_csr_do,          32'hDEAD_BEEF);
        chk("wr_we_e0",  {31'd0, a_csr_we}, 32'd1);
        chk("wr_ack_e0", {31'd0, a_ack},    32'd0);
        tick();
        chk("wr_we_e1",  {31'd0, a_csr_we}, 32'd0);
        chk("wr_ack_e1", {31'd0, a_ack},    32'd1);
        a_cyc = 0; a_stb = 0; a_we = 0;
        tick();
        chk("wr_ack_e2", {31'd0, a_ack},    32'd0);
        chk("wr_rdat_kept", a_rdat,         32'd0);

        // Read word 1, slave answers 0x7FF
        a_adr = 32'h0000_0004; a_wdat = 32'h1234_5678; a_cyc = 1; a_stb = 1;
        tick();
        chk("rd_csr_a",  {17'd0, a_csr_a},  32'h0001);
        chk("rd_we_e0",  {31'd0, a_csr_we}, 32'd0);
        tick();
        chk("rd_ack_e1", {31'd0, a_ack},    32'd0);
        tick();
        chk("rd_ack_e2", {31'd0, a_ack},    32'd1);
        chk("rd_dat",    a_rdat,            32'h0000_07FF);
        a_cyc = 0; a_stb = 0;
        tick();
        chk("rd_ack_e3", {31'd0, a_ack},    32'd0);

        // RD_LATENCY=3: early pipeline stage holds different data and must not be taken
        b_adr = 32'h0000_0008; b_cyc = 1; b_stb = 1;
        tick();
        chk("l3_csr_a",  {17'd0, b_csr_a},  32'h0002);
        tick();
        tick();
        chk("l3_ack_e2", {31'd0, b_ack},    32'd0);
        tick();
        chk("l3_ack_e3", {31'd0, b_ack},    32'd0);
        tick();
        chk("l3_ack_e4", {31'd0, b_ack},    32'd1);
        chk("l3_dat",    b_rdat,            32'hCAFE_F00D);
        b_cyc = 0; b_stb = 0;
        tick();
        chk("l3_ack_e5", {31'd0, b_ack},    32'd0);

        // Held strobe: re-accept only after ACK returns to IDLE
        a_adr = 32'h0000_2008; a_wdat = 32'hA5A5_A5A5; a_we = 1; a_cyc = 1; a_stb = 1;
        tick();
        chk("hold_we_e0",  {31'd0, a_csr_we}, 32'd1);
        chk("hold_csr_a",  {17'd0, a_csr_a},  32'h0802);
        tick();
        chk("hold_we_e1",  {31'd0, a_csr_we}, 32'd0);
        chk("hold_ack_e1", {31'd0, a_ack},    32'd1);
        tick();
        chk("hold_we_e2",  {31'd0, a_csr_we}, 32'd0);
        chk("hold_ack_e2", {31'd0, a_ack},    32'd0);
        tick();
        chk("hold_we_e3",  {31'd0, a_csr_we}, 32'd1);
        a_cyc = 0; a_stb = 0; a_we = 0;
        tick();
        chk("hold_we_e4",  {31'd0, a_csr_we}, 32'd0);
        chk("hold_ack_e4", {31'd0, a_ack},    32'd1);
        tick();
        chk("hold_ack_e5", {31'd0, a_ack},    32'd0);
        chk("hold_rdat",   a_rdat,            32'h0000_07FF);

        // Abort: strobe drops right after accept, write still completes once
        a_adr = 32'h0000_3000; a_wdat = 32'h0000_55AA; a_we = 1; a_cyc = 1; a_stb = 1;
        tick();
        chk("ab_we_e0",  {31'd0, a_csr_we}, 32'd1);
        a_cyc = 0; a_stb = 0; a_we = 0;
        tick();
        chk("ab_we_e1",  {31'd0, a_csr_we}, 32'd0);
        chk("ab_ack_e1", {31'd0, a_ack},    32'd1);
        tick();
        chk("ab_ack_e2", {31'd0, a_ack},    32'd0);
        tick();
        chk("ab_we_e3",  {31'd0, a_csr_we}, 32'd0);
        chk("ab_ack_e3", {31'd0, a_ack},    32'd0);

        // Mid-cycle asynchronous reset during RDWAIT
        a_adr = 32'h0000_0004; a_cyc = 1; a_stb = 1;
        tick();
        #3 sys_rst = 1'b1;
        #1;
        chk("mrst_ack",   {31'd0, a_ack},    32'd0);
        chk("mrst_we",    {31'd0, a_csr_we}, 32'd0);
        chk("mrst_csr_a", {17'd0, a_csr_a},  32'd0);
        chk("mrst_rdat",  a_rdat,            32'd0);
        a_cyc = 0; a_stb = 0;
        tick();
        #3 sys_rst = 1'b0;
        tick();
        chk("mrst_noack1", {31'd0, a_ack},   32'd0);
        tick();
        chk("mrst_noack2", {31'd0, a_ack},   32'd0);

        // Post-reset read through an aliased address (high and low bits ignored)
        a_adr = 32'hFFFE_0007; a_cyc = 1; a_stb = 1;
        tick();
        chk("pr_csr_a",  {17'd0, a_csr_a},  32'h0001);
        tick();
        tick();
        chk("pr_ack",    {31'd0, a_ack},    32'd1);
        chk("pr_dat",    a_rdat,            32'h0000_07FF);
        a_cyc = 0; a_stb = 0;
        tick();

        // Unmapped read: data 0, still acked
        a_adr = 32'hFFFE_0010; a_cyc = 1; a_stb = 1;
        tick();
        chk("um_csr_a",  {17'd0, a_csr_a},  32'h0004);
        tick();
        tick();
        chk("um_ack",    {31'd0, a_ack},    32'd1);
        chk("um_dat",    a_rdat,            32'd0);
        a_cyc = 0; a_stb = 0;
        tick();
        chk("um_ack_end", {31'd0, a_ack},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
